// File: rtl/record_receiver.sv
// UART 8N1 receiver that reassembles 6-byte time-tag records into 47-bit words.
// Byte0 bit7 is a framing marker (must be 0); records are MSB-first.
module record_receiver #(
  parameter int CLKS_PER_BIT = 173,
  parameter int TIMEOUT_CLKS = 3460
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  output logic [46:0] record,
  output logic        record_valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic        timeout_err,
  output logic        busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_BIT = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            rx_s1, rx_s2;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift, shift_n;
  logic            wait_high, wait_high_n;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      byte_cnt;
  logic [39:0]     partial;

  logic            byte_done;
  logic            frame_tick;
  logic            start_detect;
  logic            gap_active;
  logic            timeout_tick;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    wait_high_n  = wait_high;
    byte_done    = 1'b0;
    frame_tick   = 1'b0;
    start_detect = 1'b0;
    case (state)
      IDLE: begin
        // After a framing error the line may still be low; wait for it to recover.
        if (wait_high) begin
          if (rx_s2) wait_high_n = 1'b0;
        end else if (!rx_s2) begin
          state_n      = START;
          bit_cnt_n    = '0;
          start_detect = 1'b1;
        end
      end
      START: begin
        if (bit_cnt == HALF_BIT) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = rx_s2 ? IDLE : DATA;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          shift_n   = {rx_s2, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          state_n   = IDLE;
          if (rx_s2) begin
            byte_done = 1'b1;
          end else begin
            frame_tick  = 1'b1;
            wait_high_n = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      wait_high <= wait_high_n;
    end
  end

  assign gap_active   = (state == IDLE) && (byte_cnt != 3'd0);
  assign timeout_tick = gap_active && (gap_cnt == LAST_GAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (start_detect || !gap_active || timeout_tick) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Record assembler; error cases are mutually exclusive by construction
  // (frame/sync come from STOP, timeout only from IDLE).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt     <= '0;
      partial      <= '0;
      record       <= '0;
      record_valid <= 1'b0;
      frame_err    <= 1'b0;
      sync_err     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      record_valid <= 1'b0;
      frame_err    <= 1'b0;
      sync_err     <= 1'b0;
      timeout_err  <= 1'b0;
      if (frame_tick) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
      end else if (timeout_tick) begin
        timeout_err <= 1'b1;
        byte_cnt    <= '0;
      end else if (byte_done) begin
        if (byte_cnt == 3'd0 && shift[7]) begin
          sync_err <= 1'b1;
        end else if (byte_cnt == 3'd5) begin
          record       <= {partial[38:0], shift};
          record_valid <= 1'b1;
          byte_cnt     <= '0;
        end else begin
          partial  <= {partial[31:0], shift};
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (byte_cnt != 3'd0) || (state != IDLE);

endmodule

// File: tb/tb_record_receiver.sv
// Directed bench for record_receiver: clean records, sync/frame/timeout errors,
// back-to-back records, glitch rejection and mid-byte reset.
module tb_record_receiver;

  localparam int CPB = 8;
  localparam int TO  = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [46:0] record;
  logic        record_valid, frame_err, sync_err, timeout_err, busy;

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int rv_count = 0, sync_count = 0, frame_count = 0, to_count = 0;
  logic [46:0] rec_hist[$];
  int          rv_cycles[$];

  int s_rv, s_sync, s_frame, s_to;
  int n, diff;
  logic [46:0] rec_a, rec_b;

  record_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .record       (record),
    .record_valid (record_valid),
    .frame_err    (frame_err),
    .sync_err     (sync_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    cycle++;
    if (record_valid) begin
      rv_count++;
      rec_hist.push_back(record);
      rv_cycles.push_back(cycle);
    end
    if (sync_err)    sync_count++;
    if (frame_err)   frame_count++;
    if (timeout_err) to_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx_in = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic snap();
    s_rv    = rv_count;
    s_sync  = sync_count;
    s_frame = frame_count;
    s_to    = to_count;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_record", 64'(record), 64'd0);
    check("reset_flags", 64'({record_valid, frame_err, sync_err, timeout_err, busy}), 64'd0);
    reset_n = 1'b1;
    idle(5);

    // 1: clean record
    snap();
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
    idle(5);
    check("t1_valid_count", 64'(rv_count - s_rv), 64'd1);
    check("t1_record", 64'(record), 64'(47'h001234_56789A));
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_no_errors", 64'((sync_count - s_sync) + (frame_count - s_frame) + (to_count - s_to)), 64'd0);

    // 2: sync marker violation then resync
    snap();
    send_byte(8'h80);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    idle(5);
    check("t2_sync_count", 64'(sync_count - s_sync), 64'd1);
    check("t2_valid_count", 64'(rv_count - s_rv), 64'd1);
    check("t2_record", 64'(record), 64'(47'h01_0203040506));

    // 3a: gap just under the limit does not time out
    snap();
    send_byte(8'h00); send_byte(8'hAB);
    idle(30);
    send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01); send_byte(8'h23);
    idle(5);
    check("t3a_no_timeout", 64'(to_count - s_to), 64'd0);
    check("t3a_record", 64'(record), 64'(47'h00_ABCDEF0123));

    // 3b: partial record abandoned by timeout
    snap();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(1);
    check("t3b_busy_partial", 64'(busy), 64'd1);
    idle(60);
    check("t3b_timeout_count", 64'(to_count - s_to), 64'd1);
    check("t3b_busy_after_timeout", 64'(busy), 64'd0);
    check("t3b_record_kept", 64'(record), 64'(47'h00_ABCDEF0123));
    send_byte(8'h7F); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    idle(5);
    check("t3b_valid_count", 64'(rv_count - s_rv), 64'd1);
    check("t3b_record", 64'(record), 64'(47'h7FFF_FFFFFFFF));
    check("t3b_single_timeout", 64'(to_count - s_to), 64'd1);

    // 4: framing error mid-record, then clean record
    snap();
    send_byte(8'h00); send_byte(8'hAA);
    send_byte(8'h55, 1'b0);
    rx_in = 1'b1;
    idle(16);
    check("t4_frame_count", 64'(frame_count - s_frame), 64'd1);
    check("t4_no_valid", 64'(rv_count - s_rv), 64'd0);
    check("t4_record_kept", 64'(record), 64'(47'h7FFF_FFFFFFFF));
    check("t4_busy", 64'(busy), 64'd0);
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    send_byte(8'h67); send_byte(8'h89); send_byte(8'hAB);
    idle(5);
    check("t4_valid_count", 64'(rv_count - s_rv), 64'd1);
    check("t4_record", 64'(record), 64'(47'h01_23456789AB));

    // 5: back-to-back records, no idle bits
    snap();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h3F); send_byte(8'h0E); send_byte(8'h0D);
    send_byte(8'h0C); send_byte(8'h0B); send_byte(8'h0A);
    idle(5);
    check("t5_valid_count", 64'(rv_count - s_rv), 64'd2);
    n = rv_cycles.size();
    diff  = (n >= 2) ? rv_cycles[n-1] - rv_cycles[n-2] : -1;
    rec_a = (n >= 2) ? rec_hist[n-2] : '0;
    rec_b = (n >= 2) ? rec_hist[n-1] : '0;
    check("t5_spacing", 64'(diff), 64'(60 * CPB));
    check("t5_record_a", 64'(rec_a), 64'(47'h00_0102030405));
    check("t5_record_b", 64'(rec_b), 64'(47'h3F_0E0D0C0B0A));
    check("t5_no_errors", 64'((sync_count - s_sync) + (frame_count - s_frame) + (to_count - s_to)), 64'd0);

    // 6a: short glitch on idle line
    snap();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    idle(20);
    check("t6_glitch_pulses", 64'((rv_count - s_rv) + (sync_count - s_sync) + (frame_count - s_frame) + (to_count - s_to)), 64'd0);
    check("t6_glitch_busy", 64'(busy), 64'd0);
    check("t6_glitch_record", 64'(record), 64'(47'h3F_0E0D0C0B0A));

    // 6b: reset in the middle of a byte
    snap();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #1;
    check("t6_busy_in_flight", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_reset_record", 64'(record), 64'd0);
    check("t6_reset_flags", 64'({record_valid, frame_err, sync_err, timeout_err, busy}), 64'd0);
    rx_in = 1'b1;
    idle(4);
    reset_n = 1'b1;
    idle(20);
    check("t6_reset_no_pulses", 64'((rv_count - s_rv) + (sync_count - s_sync) + (frame_count - s_frame) + (to_count - s_to)), 64'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    idle(5);
    check("t6_recover_valid", 64'(rv_count - s_rv), 64'd1);
    check("t6_recover_record", 64'(record), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
